// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: encodings shared by the memory controller and its clients.
//   - MEM_SZ_*  : request size codes carried on ls_size (byte / half / word)
//   - ST_*      : controller state encoding (2 bits)
//   - OWN_*     : which requester currently owns the memory port
//   - size_to_len(): byte count N (1/2/4) for a size code
package mem_ctrl_pkg;

    localparam logic [1:0] MEM_SZ_B = 2'd0;
    localparam logic [1:0] MEM_SZ_H = 2'd1;
    localparam logic [1:0] MEM_SZ_W = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    // Unknown size code 3 is treated as a word access.
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        logic [2:0] len;
        case (size)
            MEM_SZ_B: len = 3'd1;
            MEM_SZ_H: len = 3'd2;
            MEM_SZ_W: len = 3'd4;
            default:  len = 3'd4;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the byte-wide RAM/IO port between instruction fetch
// (IF) and the load/store buffer (LS). Each 1/2/4-byte request is turned into
// consecutive byte transactions; little-endian data is assembled (reads) or
// split (writes). The granted requester receives a one-cycle done pulse.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rdy              global enable; low freezes every register, mem_wr forced 0
//   flush            misprediction clear; aborts reads, ignored by writes
//   if_req/if_addr   word fetch request (held until if_done)
//   if_done/if_data  fetch completion pulse and fetched word
//   ls_req/ls_we/ls_size/ls_addr/ls_wdata   load/store request (held until ls_done)
//   ls_done/ls_rdata load/store completion pulse and zero-extended load data
//   mem_din          RAM read byte, valid the cycle after its address
//   mem_dout/mem_a/mem_wr   byte write data, byte address, write strobe
//   io_buffer_full   UART buffer full; stalls writes to the IO window
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    logic [1:0]  state_reg, state_next;
    logic        owner_reg;
    logic [31:0] base_reg;
    logic [2:0]  len_reg;
    logic [2:0]  a_cnt_reg;     // bytes addressed so far
    logic [2:0]  d_cnt_reg;     // bytes captured so far (reads only)
    logic [31:0] buf_reg;       // read assembly buffer / latched store data
    logic        if_done_reg, ls_done_reg;
    logic [31:0] if_data_reg, ls_rdata_reg;

    logic [31:0] cur_addr;
    logic [31:0] rd_word;
    logic        grant_ok;
    logic        rd_issue, rd_capture, rd_last;
    logic        io_stall, wr_last;

    // 32-bit wrapping address of the byte currently being addressed.
    assign cur_addr = base_reg + {29'd0, a_cnt_reg};

    // Holding off grants while a done pulse is visible lets the requester
    // drop its req before it could be granted a second time.
    assign grant_ok = !flush && !if_done_reg && !ls_done_reg;

    // A captured byte always trails its address by one cycle, so a capture
    // is due whenever more bytes have been addressed than captured.
    assign rd_issue   = (state_reg == ST_READ) && (a_cnt_reg < len_reg);
    assign rd_capture = (state_reg == ST_READ) && (a_cnt_reg != d_cnt_reg);
    assign rd_last    = rd_capture && (d_cnt_reg == len_reg - 3'd1);

    // Writes into the IO window (addr[17:16] == 3) wait while the UART is full.
    assign io_stall = io_buffer_full && (cur_addr[17:16] == 2'b11);
    assign wr_last  = (state_reg == ST_WRITE) && !io_stall
                      && (a_cnt_reg == len_reg - 3'd1);

    // Buffer with the incoming byte merged into the lane being captured.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_word[8*gi +: 8] = (d_cnt_reg == 3'(gi)) ? mem_din
                                                              : buf_reg[8*gi +: 8];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else if (rdy) begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; LS has fixed priority over IF.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_ok) begin
                    if (ls_req) begin
                        state_next = ls_we ? ST_WRITE : ST_READ;
                    end else if (if_req) begin
                        state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (flush || rd_last) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // Stores arrive only after commit, so flush cannot cancel them.
                if (wr_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Byte sequencer: request latch, counters, data buffer and done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg    <= OWN_IF;
            base_reg     <= '0;
            len_reg      <= '0;
            a_cnt_reg    <= '0;
            d_cnt_reg    <= '0;
            buf_reg      <= '0;
            if_done_reg  <= 1'b0;
            ls_done_reg  <= 1'b0;
            if_data_reg  <= '0;
            ls_rdata_reg <= '0;
        end else if (rdy) begin
            if_done_reg <= 1'b0;
            ls_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (state_next != ST_IDLE) begin
                        owner_reg <= ls_req ? OWN_LS : OWN_IF;
                        base_reg  <= ls_req ? ls_addr : if_addr;
                        len_reg   <= ls_req ? size_to_len(ls_size) : 3'd4;
                        a_cnt_reg <= '0;
                        d_cnt_reg <= '0;
                        // Reads start from zero so unused upper bytes stay 0.
                        buf_reg   <= (ls_req && ls_we) ? ls_wdata : 32'd0;
                    end
                end
                ST_READ: begin
                    if (flush) begin
                        a_cnt_reg <= '0;
                        d_cnt_reg <= '0;
                    end else begin
                        if (rd_issue) begin
                            a_cnt_reg <= a_cnt_reg + 3'd1;
                        end
                        if (rd_capture) begin
                            buf_reg   <= rd_word;
                            d_cnt_reg <= d_cnt_reg + 3'd1;
                        end
                        if (rd_last) begin
                            a_cnt_reg <= '0;
                            d_cnt_reg <= '0;
                            if (owner_reg == OWN_LS) begin
                                ls_done_reg  <= 1'b1;
                                ls_rdata_reg <= rd_word;
                            end else begin
                                if_done_reg <= 1'b1;
                                if_data_reg <= rd_word;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (!io_stall) begin
                        if (wr_last) begin
                            a_cnt_reg   <= '0;
                            ls_done_reg <= 1'b1;
                        end else begin
                            a_cnt_reg <= a_cnt_reg + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Port outputs, decoded from the held state so they freeze with rdy low.
    always_comb begin
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        case (state_reg)
            ST_READ: begin
                if (rd_issue) begin
                    mem_a = cur_addr;
                end
            end
            ST_WRITE: begin
                mem_a    = cur_addr;
                mem_dout = buf_reg[{a_cnt_reg[1:0], 3'b000} +: 8];
                mem_wr   = rdy && !io_stall;
            end
            default: ;
        endcase
    end

    assign if_done  = if_done_reg;
    assign ls_done  = ls_done_reg;
    assign if_data  = if_data_reg;
    assign ls_rdata = ls_rdata_reg;

endmodule
